inst_seq_constraint: RTL and testbench



---
 rtl/inst_seq_constraint_if.sv | 26 ++
 rtl/inst_seq_constraint.sv | 156 +++++++++++++++
 tb/tb_inst_seq_constraint.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_seq_constraint_if.sv
// Fetch-side bus between an instruction source and the sequence constraint checker.
// The master presents instructions; the slave reports legality, class and progress.
interface inst_seq_constraint_if #(
   parameter int MAX_INSTS = 8
);
   localparam int CNT_W = $clog2(MAX_INSTS + 1);

   logic             inst_valid;
   logic [31:0]      instruction;
   logic             inst_legal;
   logic [1:0]       inst_class;
   logic [1:0]       phase;
   logic [CNT_W-1:0] issue_cnt;
   logic             done;
   logic             violation;

   modport master (
      output inst_valid, instruction,
      input  inst_legal, inst_class, phase, issue_cnt, done, violation
   );

   modport slave (
      input  inst_valid, instruction,
      output inst_legal, inst_class, phase, issue_cnt, done, violation
   );
endinterface

// File: rtl/inst_seq_constraint.sv
// Stateful legality constraint for the fetch input: per-instruction RV32IM decode,
// a bounded program of MAX_INSTS real instructions, then a forced NOP drain window.
module inst_seq_constraint #(
   parameter int REG_BITS      = 4,
   parameter int MEM_IMM_BITS  = 10,
   parameter int MAX_INSTS     = 8,
   parameter int DRAIN_CYCLES  = 16,
   parameter int ALLOW_MUL     = 1,
   parameter int ALLOW_MEM     = 1,
   parameter int NO_RAW        = 0,
   parameter int ENABLE_ASSUME = 1
) (
   input logic                  clk,
   input logic                  reset,
   inst_seq_constraint_if.slave bus
);
   localparam int CNT_W = $clog2(MAX_INSTS + 1);
   localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   localparam logic [6:0] OP_R   = 7'h33;
   localparam logic [6:0] OP_I   = 7'h13;
   localparam logic [6:0] OP_LW  = 7'h03;
   localparam logic [6:0] OP_SW  = 7'h23;
   localparam logic [6:0] OP_NOP = 7'h7F;

   typedef enum logic [1:0] {
      ISSUE = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } phase_e;

   phase_e           phase_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DRN_W-1:0] drain_q;
   logic             done_q;
   logic             viol_q, viol_d;
   logic [4:0]       last_rd_q;
   logic             last_rd_v_q;

   logic [6:0] opcode, funct7;
   logic [2:0] funct3;
   logic [4:0] rd, rs1, rs2;
   logic       is_nop, r_ok, i_ok, lw_ok, sw_ok;
   logic       uses_rs2, has_rd, raw_ok, legal, accept;
   logic [1:0] cls;

   function automatic logic reg_ok(input logic [4:0] r);
      return ({27'd0, r} >> REG_BITS) == 32'd0;
   endfunction

   function automatic logic mem_imm_ok(input logic [11:0] imm);
      return ({20'd0, imm} >> MEM_IMM_BITS) == 32'd0;
   endfunction

   assign opcode = bus.instruction[6:0];
   assign rd     = bus.instruction[11:7];
   assign funct3 = bus.instruction[14:12];
   assign rs1    = bus.instruction[19:15];
   assign rs2    = bus.instruction[24:20];
   assign funct7 = bus.instruction[31:25];
   assign is_nop = (opcode == OP_NOP);

   // SUB/SRA share funct7=0100000; MUL* occupy funct7=0000001 with funct3 0..3
   assign r_ok = (opcode == OP_R) && reg_ok(rd) && reg_ok(rs1) && reg_ok(rs2) &&
                 ((funct7 == 7'h00) ||
                  (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)) ||
                  ((ALLOW_MUL != 0) && funct7 == 7'h01 && !funct3[2]));

   assign i_ok = (opcode == OP_I) && reg_ok(rd) && reg_ok(rs1) &&
                 ((funct3 == 3'b001) ? (funct7 == 7'h00) :
                  (funct3 == 3'b101) ? (funct7 == 7'h00 || funct7 == 7'h20) : 1'b1);

   assign lw_ok = (ALLOW_MEM != 0) && (opcode == OP_LW) && (funct3 == 3'b010) &&
                  (rs1 == 5'd0) && reg_ok(rd) && mem_imm_ok(bus.instruction[31:20]);

   assign sw_ok = (ALLOW_MEM != 0) && (opcode == OP_SW) && (funct3 == 3'b010) &&
                  (rs1 == 5'd0) && reg_ok(rs2) &&
                  mem_imm_ok({bus.instruction[31:25], bus.instruction[11:7]});

   always_comb begin
      cls = 2'd0;
      if (r_ok)               cls = 2'd1;
      else if (i_ok)          cls = 2'd2;
      else if (lw_ok || sw_ok) cls = 2'd3;
   end

   assign uses_rs2 = (opcode == OP_R) || (opcode == OP_SW);
   assign has_rd   = (opcode != OP_SW);
   assign raw_ok   = (NO_RAW == 0) || !last_rd_v_q ||
                     !((rs1 == last_rd_q) || (uses_rs2 && rs2 == last_rd_q));

   always_comb begin
      legal = 1'b1;
      if (bus.inst_valid) begin
         if (phase_q == ISSUE) legal = is_nop || ((cls != 2'd0) && raw_ok);
         else                  legal = is_nop;
      end
   end

   assign accept = bus.inst_valid && (phase_q == ISSUE) && (cls != 2'd0) && raw_ok;
   assign cnt_d  = cnt_q + 1'b1;
   assign viol_d = viol_q | (bus.inst_valid & ~legal);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_q     <= ISSUE;
         cnt_q       <= '0;
         drain_q     <= '0;
         done_q      <= 1'b0;
         viol_q      <= 1'b0;
         last_rd_v_q <= 1'b0;
      end else begin
         viol_q <= viol_d;
         case (phase_q)
            ISSUE: begin
               if (accept) begin
                  cnt_q       <= cnt_d;
                  last_rd_v_q <= has_rd && (rd != 5'd0);
                  if (cnt_d == CNT_W'(MAX_INSTS)) begin
                     phase_q <= DRAIN;
                     drain_q <= '0;
                  end
               end
            end
            DRAIN: begin
               if (drain_q == DRN_W'(DRAIN_CYCLES - 1)) begin
                  phase_q <= DONE;
                  done_q  <= 1'b1;
               end else begin
                  drain_q <= drain_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // The index itself is only meaningful while last_rd_v_q is set
   always_ff @(posedge clk) begin
      if (accept) last_rd_q <= rd;
   end

   assign bus.inst_legal = legal;
   assign bus.inst_class = cls;
   assign bus.phase      = phase_q;
   assign bus.issue_cnt  = cnt_q;
   assign bus.done       = done_q;
   assign bus.violation  = viol_q;

   generate
      if (ENABLE_ASSUME != 0) begin : g_assume
         a_legal : assume property (@(posedge clk) disable iff (reset)
                                    bus.inst_valid |-> legal);
      end
   endgenerate
endmodule

// File: tb/tb_inst_seq_constraint.sv
// Bench for inst_seq_constraint: two configurations driven with identical stimulus,
// checked cycle by cycle against a behavioural model through per-DUT scoreboards.
module tb_inst_seq_constraint;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        v = 1'b0;
   logic [31:0] w = 32'h0000007F;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   inst_seq_constraint_if #(.MAX_INSTS(8)) bus_a ();
   inst_seq_constraint_if #(.MAX_INSTS(8)) bus_b ();

   assign bus_a.inst_valid  = v;
   assign bus_a.instruction = w;
   assign bus_b.inst_valid  = v;
   assign bus_b.instruction = w;

   inst_seq_constraint #(
      .REG_BITS(4), .MEM_IMM_BITS(10), .MAX_INSTS(8), .DRAIN_CYCLES(16),
      .ALLOW_MUL(1), .ALLOW_MEM(1), .NO_RAW(0), .ENABLE_ASSUME(0)
   ) u_dut_a (.clk(clk), .reset(reset), .bus(bus_a));

   inst_seq_constraint #(
      .REG_BITS(4), .MEM_IMM_BITS(10), .MAX_INSTS(8), .DRAIN_CYCLES(16),
      .ALLOW_MUL(0), .ALLOW_MEM(1), .NO_RAW(1), .ENABLE_ASSUME(0)
   ) u_dut_b (.clk(clk), .reset(reset), .bus(bus_b));

   typedef struct {
      bit chk_cls;
      bit legal;
      int cls;
      int ph;
      int cnt;
      bit done;
      bit viol;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];

   // Model state: phase 0/1/2, accepted count, drain cycles left, last dest (-1 none)
   bit cfg_mul[2] = '{1'b1, 1'b0};
   bit cfg_raw[2] = '{1'b0, 1'b1};
   int m_ph[2], m_cnt[2], m_left[2], m_last[2];
   bit m_viol[2];

   localparam bit [31:0] NOP = 32'h0000007F;

   function automatic bit [31:0] r_op(input int f7, input int rs2, input int rs1,
                                      input int f3, input int rd);
      return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
   endfunction

   function automatic bit [31:0] i_op(input int imm, input int rs1, input int f3, input int rd);
      return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), 7'h13};
   endfunction

   function automatic bit [31:0] lw_op(input int imm, input int rs1, input int rd);
      return {12'(imm), 5'(rs1), 3'b010, 5'(rd), 7'h03};
   endfunction

   function automatic bit [31:0] sw_op(input int imm, input int rs2, input int rs1);
      bit [11:0] im;
      im = 12'(imm);
      return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], 7'h23};
   endfunction

   function automatic int dec_class(input bit [31:0] x, input bit mul);
      int op, f3, f7, rd, rs1, rs2, imm;
      op = int'(x[6:0]); rd = int'(x[11:7]); f3 = int'(x[14:12]);
      rs1 = int'(x[19:15]); rs2 = int'(x[24:20]); f7 = int'(x[31:25]);
      if (op == 'h33) begin
         if (rd > 15 || rs1 > 15 || rs2 > 15) return 0;
         if (f7 == 0) return 1;
         if (f7 == 'h20 && (f3 == 0 || f3 == 5)) return 1;
         if (mul && f7 == 1 && f3 <= 3) return 1;
         return 0;
      end
      if (op == 'h13) begin
         if (rd > 15 || rs1 > 15) return 0;
         if (f3 == 1) return (f7 == 0) ? 2 : 0;
         if (f3 == 5) return (f7 == 0 || f7 == 'h20) ? 2 : 0;
         return 2;
      end
      if (op == 'h03) begin
         imm = int'(x[31:20]);
         return (f3 == 2 && rs1 == 0 && imm < 1024 && rd <= 15) ? 3 : 0;
      end
      if (op == 'h23) begin
         imm = int'({x[31:25], x[11:7]});
         return (f3 == 2 && rs1 == 0 && imm < 1024 && rs2 <= 15) ? 3 : 0;
      end
      return 0;
   endfunction

   function automatic bit m_legal(input int id, input bit vv, input bit [31:0] x);
      int op, last;
      bit nop;
      op = int'(x[6:0]);
      nop = (op == 'h7F);
      last = m_last[id];
      if (!vv) return 1'b1;
      if (m_ph[id] != 0) return nop;
      if (nop) return 1'b1;
      if (dec_class(x, cfg_mul[id]) == 0) return 1'b0;
      if (cfg_raw[id] && last >= 0) begin
         if (int'(x[19:15]) == last) return 1'b0;
         if ((op == 'h33 || op == 'h23) && int'(x[24:20]) == last) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_ph[i] = 0; m_cnt[i] = 0; m_left[i] = 0; m_last[i] = -1; m_viol[i] = 1'b0;
      end
   endtask

   task automatic model_step(input int id, input bit vv, input bit [31:0] x);
      bit lg;
      int c;
      lg = m_legal(id, vv, x);
      c = dec_class(x, cfg_mul[id]);
      if (vv && !lg) m_viol[id] = 1'b1;
      if (m_ph[id] == 0) begin
         if (vv && lg && c != 0) begin
            m_cnt[id]++;
            m_last[id] = (x[6:0] != 7'h23 && x[11:7] != 5'd0) ? int'(x[11:7]) : -1;
            if (m_cnt[id] == 8) begin
               m_ph[id] = 1;
               m_left[id] = 16;
            end
         end
      end else if (m_ph[id] == 1) begin
         m_left[id]--;
         if (m_left[id] == 0) m_ph[id] = 2;
      end
   endtask

   task automatic chk(input string nm, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
      end
   endtask

   function automatic exp_t expect_now(input int id);
      exp_t e;
      e.chk_cls = v;
      e.legal   = m_legal(id, v, w);
      e.cls     = dec_class(w, cfg_mul[id]);
      e.ph      = m_ph[id];
      e.cnt     = m_cnt[id];
      e.done    = (m_ph[id] == 2);
      e.viol    = m_viol[id];
      return e;
   endfunction

   // One clock of stimulus; rst_mid raises reset asynchronously between edges
   task automatic cycle(input bit vv, input bit [31:0] x, input bit rst_lvl, input bit rst_mid);
      @(posedge clk);
      #1;
      v = vv;
      w = x;
      reset = rst_lvl;
      if (rst_lvl) model_reset();
      if (rst_mid) begin
         #2;
         reset = 1'b1;
         model_reset();
         #1;
         chk("async_rst phase A", int'(bus_a.phase), 0);
         chk("async_rst cnt A", int'(bus_a.issue_cnt), 0);
         chk("async_rst viol A", int'(bus_a.violation), 0);
         chk("async_rst phase B", int'(bus_b.phase), 0);
         chk("async_rst viol B", int'(bus_b.violation), 0);
      end
      q_a.push_back(expect_now(0));
      q_b.push_back(expect_now(1));
      if (!reset) begin
         model_step(0, vv, x);
         model_step(1, vv, x);
      end
   endtask

   task automatic compare(input string tag, input exp_t e, input logic lg, input logic [1:0] cl,
                          input logic [1:0] ph, input logic [3:0] cn, input logic dn,
                          input logic vi);
      chk({tag, " inst_legal"}, int'(lg), int'(e.legal));
      if (e.chk_cls) chk({tag, " inst_class"}, int'(cl), e.cls);
      chk({tag, " phase"}, int'(ph), e.ph);
      chk({tag, " issue_cnt"}, int'(cn), e.cnt);
      chk({tag, " done"}, int'(dn), int'(e.done));
      chk({tag, " violation"}, int'(vi), int'(e.viol));
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (q_a.size() > 0) begin
         e = q_a.pop_front();
         compare("A", e, bus_a.inst_legal, bus_a.inst_class, bus_a.phase, bus_a.issue_cnt,
                 bus_a.done, bus_a.violation);
      end
      if (q_b.size() > 0) begin
         e = q_b.pop_front();
         compare("B", e, bus_b.inst_legal, bus_b.inst_class, bus_b.phase, bus_b.issue_cnt,
                 bus_b.done, bus_b.violation);
      end
   end

   function automatic int pick_reg();
      return ($urandom_range(0, 11) == 0) ? int'($urandom_range(16, 31))
                                          : int'($urandom_range(0, 15));
   endfunction

   function automatic bit [31:0] rand_inst(input int prev_rd);
      int sel, f7;
      sel = int'($urandom_range(0, 9));
      case (sel)
         0, 9: return NOP;
         1, 2: begin
            case ($urandom_range(0, 3))
               0, 1: f7 = 0;
               2: f7 = ($urandom_range(0, 1) != 0) ? 'h20 : 1;
               default: f7 = int'($urandom_range(0, 127));
            endcase
            return r_op(f7, pick_reg(), pick_reg(), int'($urandom_range(0, 7)), pick_reg());
         end
         3, 4: begin
            f7 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) :
                 (($urandom_range(0, 1) != 0) ? 'h20 : 0);
            return i_op((f7 << 5) | int'($urandom_range(0, 31)), pick_reg(),
                        int'($urandom_range(0, 7)), pick_reg());
         end
         5: return lw_op(($urandom_range(0, 3) == 0) ? int'($urandom_range(1024, 4095))
                                                     : int'($urandom_range(0, 1023)),
                         ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 15)) : 0,
                         pick_reg());
         6: return sw_op(($urandom_range(0, 3) == 0) ? int'($urandom_range(1024, 4095))
                                                     : int'($urandom_range(0, 1023)),
                         pick_reg(),
                         ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 15)) : 0);
         7: return $urandom;
         default: return r_op(0, int'($urandom_range(0, 15)), prev_rd, 0,
                              int'($urandom_range(1, 15)));
      endcase
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int prev_rd;
      bit [31:0] x;
      model_reset();
      // Reset state, then a full 8-instruction program through drain to DONE
      cycle(1'b0, NOP, 1'b1, 1'b0);
      cycle(1'b0, NOP, 1'b1, 1'b0);
      for (int r = 1; r <= 8; r++) cycle(1'b1, r_op(0, 0, 0, 0, r), 1'b0, 1'b0);
      for (int i = 0; i < 19; i++) cycle(i % 3 != 0, NOP, 1'b0, 1'b0);
      cycle(1'b1, i_op(1, 0, 0, 2), 1'b0, 1'b0);
      // Out-of-range rd, then MUL legality per configuration
      cycle(1'b0, NOP, 1'b1, 1'b0);
      cycle(1'b1, r_op(0, 0, 0, 0, 16), 1'b0, 1'b0);
      cycle(1'b1, NOP, 1'b0, 1'b0);
      cycle(1'b0, NOP, 1'b1, 1'b0);
      cycle(1'b1, r_op(1, 3, 2, 0, 1), 1'b0, 1'b0);
      cycle(1'b1, NOP, 1'b0, 1'b0);
      // Memory forms
      cycle(1'b0, NOP, 1'b1, 1'b0);
      cycle(1'b1, lw_op('h3FC, 0, 3), 1'b0, 1'b0);
      cycle(1'b1, lw_op('h400, 0, 3), 1'b0, 1'b0);
      cycle(1'b1, sw_op(4, 2, 1), 1'b0, 1'b0);
      cycle(1'b1, sw_op('h3FC, 2, 0), 1'b0, 1'b0);
      // RAW rule: direct, across a NOP, and through x0
      cycle(1'b0, NOP, 1'b1, 1'b0);
      cycle(1'b1, i_op(1, 0, 0, 5), 1'b0, 1'b0);
      cycle(1'b1, r_op(0, 0, 5, 0, 6), 1'b0, 1'b0);
      cycle(1'b0, NOP, 1'b1, 1'b0);
      cycle(1'b1, i_op(1, 0, 0, 5), 1'b0, 1'b0);
      cycle(1'b1, NOP, 1'b0, 1'b0);
      cycle(1'b1, r_op(0, 0, 5, 0, 6), 1'b0, 1'b0);
      cycle(1'b0, NOP, 1'b1, 1'b0);
      cycle(1'b1, i_op(1, 0, 0, 0), 1'b0, 1'b0);
      cycle(1'b1, r_op(0, 0, 0, 0, 6), 1'b0, 1'b0);
      cycle(1'b1, r_op(0, 6, 0, 0, 7), 1'b0, 1'b0);
      // Illegal ADDI during drain, then asynchronous reset mid-drain
      cycle(1'b0, NOP, 1'b1, 1'b0);
      for (int r = 1; r <= 8; r++) cycle(1'b1, r_op(0, 0, 0, 0, r), 1'b0, 1'b0);
      cycle(1'b1, i_op(3, 0, 0, 4), 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, NOP, 1'b0, 1'b0);
      cycle(1'b1, NOP, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b1, r_op(0, 0, 0, 0, 9), 1'b0, 1'b0);
      // Randomised traffic with occasional resets
      prev_rd = 0;
      for (int i = 0; i < 1500; i++) begin
         x = rand_inst(prev_rd);
         if (x[6:0] != 7'h23) prev_rd = int'(x[11:7]) & 15;
         cycle($urandom_range(0, 4) != 0, x, $urandom_range(0, 79) == 0, 1'b0);
      end
      cycle(1'b0, NOP, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      chk("scoreboard A drained", q_a.size(), 0);
      chk("scoreboard B drained", q_b.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
